// File: rtl/execute_md_pkg.sv
// Shared types for the execute stage: control word, ALU/branch/mul-div opcodes, mul/div FSM states,
// plus the combinational ALU and branch helpers used by execute_md.
package execute_md_pkg;

  localparam int RVGA_XLEN = 32;
  typedef logic [RVGA_XLEN-1:0] rvga_word;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } aluop_e;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } mdop_e;

  typedef enum logic [3:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR
  } brop_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;
  typedef enum logic       {OP1_RS1, OP1_IMM} op1_sel_e;
  typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;
  typedef enum logic       {PC_PLUS4, PC_JMP} pcmux_e;

  typedef struct packed {
    aluop_e   aluop;
    mdop_e    mdop;
    logic     md_enable;
    op1_sel_e op1_sel;
    op2_sel_e op2_sel;
    brop_e    brop;
    rvga_word rs1_data;
    rvga_word rs2_data;
    rvga_word imm;
    rvga_word pc;
    rvga_word rd_data;
    rvga_word jmp_tgt;
    pcmux_e   pcmux_sel;
  } rvga_cword;

  function automatic rvga_word alu_f(input aluop_e op, input rvga_word a, input rvga_word b);
    logic [$clog2(RVGA_XLEN)-1:0] sh;
    sh = b[$clog2(RVGA_XLEN)-1:0];
    case (op)
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << sh;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return rvga_word'($signed(a) >>> sh);
      ALU_SLT:   return rvga_word'($signed(a) < $signed(b));
      ALU_SLTU:  return rvga_word'(a < b);
      ALU_PASSB: return b;
      default:   return a + b;
    endcase
  endfunction

  function automatic logic br_taken(input brop_e op, input rvga_word a, input rvga_word b);
    case (op)
      BR_EQ:            return a == b;
      BR_NE:            return a != b;
      BR_LT:            return $signed(a) < $signed(b);
      BR_GE:            return $signed(a) >= $signed(b);
      BR_LTU:           return a < b;
      BR_GEU:           return a >= b;
      BR_JAL, BR_JALR:  return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic rvga_word br_target(input brop_e op, input rvga_word pc, input rvga_word rs1,
                                         input rvga_word imm);
    rvga_word t;
    t = (op == BR_JALR) ? (rs1 + imm) : (pc + imm);
    if (op == BR_JALR) t[0] = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/execute_md_mdu.sv
// Multi-cycle RV32M unit: latency-modelled multiplier and radix-2 restoring divider.
// Signed divides run on magnitudes; signs are reapplied on the result path in DONE.
module md_unit
  import execute_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            hold,
  input  mdop_e           mdop,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output md_state_e       state,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + MUL_CYCLES + 1);

  md_state_e       state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  mdop_e           op_reg;
  logic [XLEN-1:0] a_reg, b_reg, quo_reg, rem_reg, dvsr_reg;
  logic            neg_q_reg, neg_r_reg;

  logic            sgn_div, a_neg, b_neg;
  logic [XLEN:0]   r_shift;
  logic            fits;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign sgn_div = (mdop == MD_DIV) || (mdop == MD_REM);
  assign a_neg   = sgn_div & op_a[XLEN-1];
  assign b_neg   = sgn_div & op_b[XLEN-1];
  assign r_shift = {rem_reg, quo_reg[XLEN-1]};
  assign fits    = r_shift >= {1'b0, dvsr_reg};
  assign state   = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = IDLE;
    end else if (!hold) begin
      case (state_reg)
        IDLE: if (start) state_next = mdop[2] ? DIV : MUL;
        MUL:  if (cnt_reg == '0) state_next = DONE;
        DIV:  if (cnt_reg == '0) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      op_reg    <= MD_MUL;
      a_reg     <= '0;
      b_reg     <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (!kill && !hold) begin
      if (state_reg == IDLE && start) begin
        op_reg    <= mdop;
        a_reg     <= op_a;
        b_reg     <= op_b;
        quo_reg   <= a_neg ? -op_a : op_a;
        dvsr_reg  <= b_neg ? -op_b : op_b;
        rem_reg   <= '0;
        // Divide-by-zero keeps the all-ones quotient unsigned-looking: never negate it.
        neg_q_reg <= (a_neg ^ b_neg) && (op_b != '0);
        neg_r_reg <= a_neg;
        cnt_reg   <= mdop[2] ? CW'(XLEN - 1) : CW'(MUL_CYCLES - 1);
      end else if (state_reg == DIV) begin
        quo_reg <= {quo_reg[XLEN-2:0], fits};
        rem_reg <= fits ? (r_shift[XLEN-1:0] - dvsr_reg) : r_shift[XLEN-1:0];
        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      end else if (state_reg == MUL) begin
        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  always_comb begin
    ext_a = {{XLEN{((op_reg == MD_MULH) || (op_reg == MD_MULHSU)) & a_reg[XLEN-1]}}, a_reg};
    ext_b = {{XLEN{(op_reg == MD_MULH) & b_reg[XLEN-1]}}, b_reg};
    prod  = ext_a * ext_b;
    quo_fix = neg_q_reg ? -quo_reg : quo_reg;
    rem_fix = neg_r_reg ? -rem_reg : rem_reg;
    case (op_reg)
      MD_MUL:                      result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result = quo_fix;
      default:                     result = rem_fix;
    endcase
  end

endmodule

// File: rtl/execute_md.sv
// Execute stage: single-cycle ALU/branch path plus optional multi-cycle mul/div unit, with
// ex_busy holding the front of the pipe while a mul/div op iterates.
module execute_md
  import execute_md_pkg::*;
#(
  parameter int XLEN       = RVGA_XLEN,
  parameter int MUL_CYCLES = 2,
  parameter int ENABLE_M   = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      stall,
  input  logic      flush,
  input  logic      rf_ex_valid,
  input  rvga_cword rf_ex_cword,
  output logic      ex_busy,
  output logic      ex_mem_valid,
  output rvga_cword ex_mem_cword
);

  localparam logic M_ON = (ENABLE_M != 0);

  rvga_word  op1, op2, alu_res, md_result;
  rvga_cword alu_cw, md_cw, cw_lat_reg;
  md_state_e md_state;
  logic      md_sel, md_start;

  assign md_sel   = M_ON & rf_ex_cword.md_enable;
  assign md_start = rf_ex_valid & md_sel & ~flush & ~stall & (md_state == IDLE);

  always_comb begin
    op1 = (rf_ex_cword.op1_sel == OP1_IMM) ? rf_ex_cword.imm : rf_ex_cword.rs1_data;
    case (rf_ex_cword.op2_sel)
      OP2_IMM:  op2 = rf_ex_cword.imm;
      OP2_FOUR: op2 = rvga_word'(4);
      default:  op2 = rf_ex_cword.rs2_data;
    endcase
    alu_res          = alu_f(rf_ex_cword.aluop, op1, op2);
    alu_cw           = rf_ex_cword;
    alu_cw.rd_data   = alu_res;
    alu_cw.jmp_tgt   = br_target(rf_ex_cword.brop, rf_ex_cword.pc, rf_ex_cword.rs1_data,
                                 rf_ex_cword.imm);
    alu_cw.pcmux_sel = br_taken(rf_ex_cword.brop, rf_ex_cword.rs1_data, rf_ex_cword.rs2_data)
                       ? PC_JMP : PC_PLUS4;
    md_cw            = cw_lat_reg;
    md_cw.rd_data    = md_result;
    md_cw.jmp_tgt    = '0;
    md_cw.pcmux_sel  = PC_PLUS4;
  end

  // Busy drops in DONE as soon as the result can leave, so upstream advances on that same edge.
  always_comb begin
    ex_busy = 1'b1;
    case (md_state)
      IDLE:    ex_busy = md_start;
      DONE:    ex_busy = stall;
      default: ex_busy = 1'b1;
    endcase
  end

  generate
    if (ENABLE_M != 0) begin : g_md
      md_unit #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .kill   (flush),
        .hold   (stall),
        .mdop   (rf_ex_cword.mdop),
        .op_a   (rf_ex_cword.rs1_data),
        .op_b   (rf_ex_cword.rs2_data),
        .state  (md_state),
        .result (md_result)
      );
    end else begin : g_no_md
      assign md_state  = IDLE;
      assign md_result = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cw_lat_reg <= '0;
    else if (md_start) cw_lat_reg <= rf_ex_cword;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_valid <= 1'b0;
      ex_mem_cword <= '0;
    end else if (flush) begin
      ex_mem_valid <= 1'b0;
    end else if (!stall) begin
      case (md_state)
        IDLE: begin
          ex_mem_cword <= alu_cw;
          ex_mem_valid <= rf_ex_valid & ~md_sel;
        end
        DONE: begin
          ex_mem_cword <= md_cw;
          ex_mem_valid <= 1'b1;
        end
        default: ex_mem_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: ALU op, mul/div results and latencies, flush, stall and async reset.
module tb_execute_md;
  import execute_md_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n, stall, flush, rf_ex_valid;
  rvga_cword rf_ex_cword;
  logic      ex_busy, ex_mem_valid;
  rvga_cword ex_mem_cword;

  int n_total = 0;
  int n_pass  = 0;

  execute_md #(.XLEN(32), .MUL_CYCLES(2), .ENABLE_M(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .rf_ex_valid  (rf_ex_valid),
    .rf_ex_cword  (rf_ex_cword),
    .ex_busy      (ex_busy),
    .ex_mem_valid (ex_mem_valid),
    .ex_mem_cword (ex_mem_cword)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic rvga_cword mk_alu(input aluop_e op, input logic [31:0] a, input logic [31:0] b);
    rvga_cword c;
    c = '0;
    c.aluop = op;
    c.rs1_data = a;
    c.rs2_data = b;
    c.pc = 32'h100;
    return c;
  endfunction

  function automatic rvga_cword mk_md(input mdop_e op, input logic [31:0] a, input logic [31:0] b);
    rvga_cword c;
    c = '0;
    c.md_enable = 1'b1;
    c.mdop = op;
    c.rs1_data = a;
    c.rs2_data = b;
    c.pc = 32'h200;
    return c;
  endfunction

  // Issue one mul/div op, count combinational busy cycles, then sample the emitted result.
  task automatic md_op(input mdop_e op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int nbusy, output logic vld);
    @(negedge clk);
    rf_ex_cword = mk_md(op, a, b);
    rf_ex_valid = 1'b1;
    #1;
    nbusy = 0;
    while (ex_busy && nbusy < 200) begin
      nbusy++;
      @(negedge clk);
      #1;
    end
    rf_ex_valid = 1'b0;
    @(negedge clk);
    res = ex_mem_cword.rd_data;
    vld = ex_mem_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int          nb;
    logic        vld;

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; rf_ex_valid = 1'b0; rf_ex_cword = '0;
    #1;
    check("reset_busy", {31'b0, ex_busy}, 32'd0);
    check("reset_valid", {31'b0, ex_mem_valid}, 32'd0);
    check("reset_cword_zero", {31'b0, ex_mem_cword == '0}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // ADD 5 + -3
    @(negedge clk);
    rf_ex_cword = mk_alu(ALU_ADD, 32'd5, 32'hFFFF_FFFD);
    rf_ex_valid = 1'b1;
    #1 check("add_busy", {31'b0, ex_busy}, 32'd0);
    @(negedge clk);
    check("add_valid", {31'b0, ex_mem_valid}, 32'd1);
    check("add_rd", ex_mem_cword.rd_data, 32'd2);
    rf_ex_valid = 1'b0;

    md_op(MD_MULH, 32'h8000_0000, 32'h8000_0000, res, nb, vld);
    check("mulh_busy_cycles", nb, 32'd3);
    check("mulh_valid", {31'b0, vld}, 32'd1);
    check("mulh_rd", res, 32'h4000_0000);
    check("mulh_pcmux", {31'b0, ex_mem_cword.pcmux_sel}, 32'd0);

    md_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, res, nb, vld);
    check("div_busy_cycles", nb, 32'd33);
    check("div_valid", {31'b0, vld}, 32'd1);
    check("div_rd", res, 32'hFFFF_FFFD);

    md_op(MD_REM, 32'hFFFF_FFF9, 32'd2, res, nb, vld);
    check("rem_rd", res, 32'hFFFF_FFFF);

    md_op(MD_DIVU, 32'h0000_1234, 32'd0, res, nb, vld);
    check("divu_zero_busy_cycles", nb, 32'd33);
    check("divu_zero_rd", res, 32'hFFFF_FFFF);

    md_op(MD_REMU, 32'h0000_1234, 32'd0, res, nb, vld);
    check("remu_zero_rd", res, 32'h0000_1234);

    md_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, nb, vld);
    check("div_ovf_rd", res, 32'h8000_0000);
    md_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, nb, vld);
    check("rem_ovf_rd", res, 32'd0);

    md_op(MD_MUL, 32'hFFFF_FFFD, 32'd7, res, nb, vld);
    check("mul_low_rd", res, 32'hFFFF_FFEB);

    // Flush partway through a divide
    @(negedge clk);
    rf_ex_cword = mk_md(MD_DIV, 32'd100, 32'd7);
    rf_ex_valid = 1'b1;
    repeat (10) @(negedge clk);
    #1 check("flush_busy_before", {31'b0, ex_busy}, 32'd1);
    flush = 1'b1; rf_ex_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy_after", {31'b0, ex_busy}, 32'd0);
    check("flush_no_valid", {31'b0, ex_mem_valid}, 32'd0);
    rf_ex_cword = mk_alu(ALU_ADD, 32'd5, 32'hFFFF_FFFD);
    rf_ex_valid = 1'b1;
    @(negedge clk);
    check("post_flush_add_valid", {31'b0, ex_mem_valid}, 32'd1);
    check("post_flush_add_rd", ex_mem_cword.rd_data, 32'd2);
    rf_ex_valid = 1'b0;

    // Stall held five cycles while the multiply sits in DONE
    @(negedge clk);
    rf_ex_cword = mk_md(MD_MUL, 32'd6, 32'd7);
    rf_ex_valid = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_busy", {31'b0, ex_busy}, 32'd1);
      check("stall_valid_held", {31'b0, ex_mem_valid}, 32'd0);
    end
    stall = 1'b0;
    #1 check("stall_release_busy", {31'b0, ex_busy}, 32'd0);
    rf_ex_valid = 1'b0;
    @(negedge clk);
    check("stall_emit_valid", {31'b0, ex_mem_valid}, 32'd1);
    check("stall_emit_rd", ex_mem_cword.rd_data, 32'd42);

    // ALU result in the output register, then async reset in the middle of a divide
    @(negedge clk);
    rf_ex_cword = mk_alu(ALU_SUB, 32'd9, 32'd4);
    rf_ex_valid = 1'b1;
    @(negedge clk);
    check("sub_rd", ex_mem_cword.rd_data, 32'd5);
    rf_ex_cword = mk_md(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0; rf_ex_valid = 1'b0;
    #1;
    check("arst_busy", {31'b0, ex_busy}, 32'd0);
    check("arst_valid", {31'b0, ex_mem_valid}, 32'd0);
    check("arst_cword_zero", {31'b0, ex_mem_cword == '0}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    md_op(MD_DIVU, 32'd100, 32'd7, res, nb, vld);
    check("post_reset_divu_rd", res, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
